// File: rtl/data_memory_responder_if.sv
// MEM-stage data-memory bus: requester drives op/address/store data, responder returns load data.
// memReady is a one-cycle completion pulse; memStall holds the requester while a transfer is open.
interface data_memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            memAccessControl;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;
  logic                  memReady;
  logic                  memStall;
  logic                  addrError;

  modport master (
    output memAccessControl, address, writeData,
    input  readData, memReady, memStall, addrError
  );

  modport slave (
    input  memAccessControl, address, writeData,
    output readData, memReady, memStall, addrError
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: word array behind an IDLE/WAIT/DONE FSM, WAIT_STATES+1 cycles request to memReady.
// Backpressure: memStall is high on the accepting IDLE cycle and through WAIT, low on the memReady cycle.
module data_memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  resetN,
  data_memory_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_op_wr;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_aerr;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_op_wr;
  logic                  w_valid;
  logic [31:0]           w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_BITS-1:0]  w_idx;

  assign w_req    = (bus.memAccessControl == 2'b01) || (bus.memAccessControl == 2'b10);
  assign w_accept = (r_state == S_IDLE) && w_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = (WS == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The op executes on the edge entering DONE; with zero wait states that edge is the
  // accepting one, so the operands come straight from the bus instead of the latches.
  assign w_fire  = (w_next == S_DONE);
  assign w_op_wr = (r_state == S_IDLE) ? (bus.memAccessControl == 2'b10) : r_op_wr;
  assign w_addr  = (r_state == S_IDLE) ? bus.address : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? bus.writeData : r_wdata;
  assign w_valid = (w_addr[31:ADDR_BITS] == '0);
  assign w_idx   = w_addr[ADDR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_aerr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_fire;
      r_aerr  <= w_fire && !w_valid;
      if (w_accept) begin
        r_op_wr <= (bus.memAccessControl == 2'b10);
        r_addr  <= bus.address;
        r_wdata <= bus.writeData;
        r_cnt   <= WS;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !w_op_wr) r_rdata <= w_valid ? r_mem[w_idx] : '0;
    end
  end

  // Array contents survive reset; an in-flight write is simply dropped.
  always_ff @(posedge clk) begin
    if (resetN && w_fire && w_op_wr && w_valid) r_mem[w_idx] <= w_wdata;
  end

  assign bus.readData  = r_rdata;
  assign bus.memReady  = r_ready;
  assign bus.addrError = r_aerr;
  assign bus.memStall  = w_accept || (r_state == S_WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_memory_responder_if #(.DATA_WIDTH(32)) bus ();
  data_memory_responder_if #(.DATA_WIDTH(32)) bus0 ();

  data_memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(2)) dut (
    .clk(clk), .resetN(resetN), .bus(bus.slave)
  );

  data_memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .resetN(resetN), .bus(bus0.slave)
  );

  // Runs one transfer on the 2-wait-state instance starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic xfer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int stalls, output logic [31:0] rd,
                      output logic ae, output logic dstall);
    bus.memAccessControl = op;
    bus.address = a;
    bus.writeData = d;
    lat = 0;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.memStall === 1'b1) stalls++;
      @(posedge clk); #1;
      lat++;
      if (bus.memReady === 1'b1) break;
    end
    rd = bus.readData;
    ae = bus.addrError;
    dstall = bus.memStall;
    bus.memAccessControl = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    bus.memAccessControl = 2'b00; bus.address = '0; bus.writeData = '0;
    bus0.memAccessControl = 2'b00; bus0.address = '0; bus0.writeData = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.readData !== 32'd0) begin n_bad++; $display("FAIL reset_readData: got %h want 0", bus.readData); end
    n_cmp++; if (bus.memReady !== 1'b0) begin n_bad++; $display("FAIL reset_memReady: got %b want 0", bus.memReady); end
    n_cmp++; if (bus.memStall !== 1'b0) begin n_bad++; $display("FAIL reset_memStall: got %b want 0", bus.memStall); end
    n_cmp++; if (bus.addrError !== 1'b0) begin n_bad++; $display("FAIL reset_addrError: got %b want 0", bus.addrError); end
    n_cmp++; if (bus0.memReady !== 1'b0 || bus0.readData !== 32'd0) begin n_bad++; $display("FAIL reset_ws0: got ready %b data %h want 0/0", bus0.memReady, bus0.readData); end
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat, st; logic [31:0] rd; logic ae, ds;
    xfer(2'b10, 32'd100, 32'd20, lat, st, rd, ae, ds);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL wr_stall_cycles: got %0d want 3", st); end
    n_cmp++; if (ds !== 1'b0) begin n_bad++; $display("FAIL wr_stall_in_done: got %b want 0", ds); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL wr_keeps_readData: got %h want 0", rd); end
    n_cmp++; if (ae !== 1'b0) begin n_bad++; $display("FAIL wr_addrError: got %b want 0", ae); end
    xfer(2'b01, 32'd100, 32'd0, lat, st, rd, ae, ds);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'd20) begin n_bad++; $display("FAIL rd_100: got %h want 14", rd); end
    n_cmp++; if (bus.readData !== 32'd20) begin n_bad++; $display("FAIL rd_100_hold: got %h want 14", bus.readData); end
  endtask

  task automatic test_mid_wait_change;
    int lat, st; logic [31:0] rd; logic ae, ds;
    xfer(2'b10, 32'd3, 32'd200, lat, st, rd, ae, ds);
    bus.memAccessControl = 2'b01; bus.address = 32'd3; bus.writeData = 32'd0;
    @(posedge clk); #1;
    bus.memAccessControl = 2'b10; bus.address = 32'd5; bus.writeData = 32'd999;
    n_cmp++; if (bus.memStall !== 1'b1) begin n_bad++; $display("FAIL midwait_stall: got %b want 1", bus.memStall); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (bus.memReady !== 1'b1) begin n_bad++; $display("FAIL midwait_ready: got %b want 1", bus.memReady); end
    n_cmp++; if (bus.readData !== 32'd200) begin n_bad++; $display("FAIL midwait_data: got %h want c8", bus.readData); end
    n_cmp++; if (bus.memStall !== 1'b0) begin n_bad++; $display("FAIL midwait_done_stall: got %b want 0", bus.memStall); end
    bus.memAccessControl = 2'b00;
    @(posedge clk); #1;
    xfer(2'b01, 32'd3, 32'd0, lat, st, rd, ae, ds);
    n_cmp++; if (rd !== 32'd200) begin n_bad++; $display("FAIL midwait_addr3_intact: got %h want c8", rd); end
  endtask

  task automatic test_range;
    int lat, st; logic [31:0] rd; logic ae, ds;
    xfer(2'b10, 32'd0, 32'd11, lat, st, rd, ae, ds);
    xfer(2'b10, 32'h0000_0100, 32'd99, lat, st, rd, ae, ds);
    n_cmp++; if (ae !== 1'b1) begin n_bad++; $display("FAIL range_wr_addrError: got %b want 1", ae); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL range_wr_latency: got %0d want 3", lat); end
    n_cmp++; if (bus.addrError !== 1'b0) begin n_bad++; $display("FAIL range_addrError_pulse: got %b want 0", bus.addrError); end
    xfer(2'b01, 32'd0, 32'd0, lat, st, rd, ae, ds);
    n_cmp++; if (rd !== 32'd11) begin n_bad++; $display("FAIL range_addr0_intact: got %h want b", rd); end
    n_cmp++; if (ae !== 1'b0) begin n_bad++; $display("FAIL range_addr0_addrError: got %b want 0", ae); end
    xfer(2'b01, 32'h0000_0100, 32'd0, lat, st, rd, ae, ds);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL range_rd_data: got %h want 0", rd); end
    n_cmp++; if (ae !== 1'b1) begin n_bad++; $display("FAIL range_rd_addrError: got %b want 1", ae); end
  endtask

  task automatic test_ctrl3_ws0;
    bus.memAccessControl = 2'b11; bus.address = 32'd100; bus.writeData = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.memStall !== 1'b0) begin n_bad++; $display("FAIL ctrl3_stall[%0d]: got %b want 0", i, bus.memStall); end
      @(posedge clk); #1;
      n_cmp++; if (bus.memReady !== 1'b0) begin n_bad++; $display("FAIL ctrl3_ready[%0d]: got %b want 0", i, bus.memReady); end
    end
    n_cmp++; if (bus.readData !== 32'd0) begin n_bad++; $display("FAIL ctrl3_readData: got %h want 0", bus.readData); end
    bus.memAccessControl = 2'b00;
    bus0.memAccessControl = 2'b10; bus0.address = 32'd9; bus0.writeData = 32'h0000_ABCD;
    #1;
    n_cmp++; if (bus0.memStall !== 1'b1) begin n_bad++; $display("FAIL ws0_wr_stall: got %b want 1", bus0.memStall); end
    @(posedge clk); #1;
    n_cmp++; if (bus0.memReady !== 1'b1) begin n_bad++; $display("FAIL ws0_wr_ready: got %b want 1", bus0.memReady); end
    bus0.memAccessControl = 2'b00;
    @(posedge clk); #1;
    bus0.memAccessControl = 2'b01;
    @(posedge clk); #1;
    n_cmp++; if (bus0.memReady !== 1'b1) begin n_bad++; $display("FAIL ws0_rd_ready: got %b want 1", bus0.memReady); end
    n_cmp++; if (bus0.readData !== 32'h0000_ABCD) begin n_bad++; $display("FAIL ws0_rd_data: got %h want abcd", bus0.readData); end
    bus0.memAccessControl = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (bus0.memReady !== 1'b0) begin n_bad++; $display("FAIL ws0_ready_pulse: got %b want 0", bus0.memReady); end
  endtask

  task automatic test_reset_abort;
    int lat, st; logic [31:0] rd; logic ae, ds;
    xfer(2'b10, 32'd7, 32'd77, lat, st, rd, ae, ds);
    bus.memAccessControl = 2'b10; bus.address = 32'd7; bus.writeData = 32'd55;
    @(posedge clk); #1;
    resetN = 1'b0;
    bus.memAccessControl = 2'b00;
    @(posedge clk); #1;
    resetN = 1'b1;
    n_cmp++; if (bus.memStall !== 1'b0) begin n_bad++; $display("FAIL abort_stall: got %b want 0", bus.memStall); end
    n_cmp++; if (bus.memReady !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", bus.memReady); end
    @(posedge clk); #1;
    n_cmp++; if (bus.memReady !== 1'b0) begin n_bad++; $display("FAIL abort_no_late_ready: got %b want 0", bus.memReady); end
    xfer(2'b01, 32'd7, 32'd0, lat, st, rd, ae, ds);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL abort_idle_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'd77) begin n_bad++; $display("FAIL abort_addr7_old: got %h want 4d", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mid_wait_change();
    test_range();
    test_ctrl3_ws0();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
